// File: rtl/bitstream_encoder_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_encoder_tx
//  Description : Serialises one packet descriptor (PID, addr, endp, 64-bit
//                data) into a single-bit stream: SYNC, PID byte, token fields
//                with CRC5 or DATA0 payload with CRC16. One bit leaves per
//                non-paused cycle; the downstream stuffer stalls us via pause.
//  Ports       : clk        system clock, all state on posedge
//                rst_L      asynchronous active-low reset
//                pkt_start  send request, taken only while ready=1
//                pid/addr/endp/data  descriptor, latched on acceptance
//                pause      freeze outb and all state this cycle
//                ready      idle, able to accept pkt_start
//                sending    outb carries a valid packet bit
//                outb       serial bit
//                done       one-cycle pulse after the last bit
//                error      one-cycle pulse on pkt_start with unknown pid
//  Revision    : 1.0  initial release
// ============================================================================
module bitstream_encoder_tx #(
    parameter logic [7:0] SYNC_PAT = 8'b1000_0000
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        pkt_start,
    input  logic [3:0]  pid,
    input  logic [6:0]  addr,
    input  logic [3:0]  endp,
    input  logic [63:0] data,
    input  logic        pause,
    output logic        ready,
    output logic        sending,
    output logic        outb,
    output logic        done,
    output logic        error
);

    localparam logic [3:0] c_PID_OUT   = 4'b0001;
    localparam logic [3:0] c_PID_IN    = 4'b1001;
    localparam logic [3:0] c_PID_DATA0 = 4'b0011;
    localparam logic [3:0] c_PID_ACK   = 4'b0010;
    localparam logic [3:0] c_PID_NAK   = 4'b1010;

    localparam logic [4:0]  c_CRC5_POLY  = 5'b00101;
    localparam logic [15:0] c_CRC16_POLY = 16'h8005;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SYNC  = 4'd1,
        S_PID   = 4'd2,
        S_ADDR  = 4'd3,
        S_ENDP  = 4'd4,
        S_CRC5  = 4'd5,
        S_DATA  = 4'd6,
        S_CRC16 = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [3:0]  r_pid;
    logic [6:0]  r_addr;
    logic [3:0]  r_endp;
    logic [63:0] r_data;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;
    logic        r_ready;
    logic        r_sending;
    logic        r_outb;
    logic        r_done;
    logic        r_error;

    state_t      w_state_nxt;
    logic [6:0]  w_cnt_nxt;
    logic [6:0]  w_last;
    logic        w_field;
    logic        w_adv;
    logic        w_pid_ok;
    logic        w_accept;
    logic        w_reject;
    logic [4:0]  w_crc5_nxt;
    logic [15:0] w_crc16_nxt;
    logic [7:0]  w_pid_byte;
    logic [2:0]  w_idx5;
    logic [3:0]  w_idx16;
    logic        w_bit_nxt;

    function automatic logic [4:0] f_crc5_step(input logic [4:0] c, input logic b);
        logic [4:0] n;
        n = {c[3:0], 1'b0};
        if (c[4] ^ b) n = n ^ c_CRC5_POLY;
        return n;
    endfunction

    function automatic logic [15:0] f_crc16_step(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = {c[14:0], 1'b0};
        if (c[15] ^ b) n = n ^ c_CRC16_POLY;
        return n;
    endfunction

    assign w_pid_ok = (pid == c_PID_OUT) || (pid == c_PID_IN) || (pid == c_PID_DATA0) ||
                      (pid == c_PID_ACK) || (pid == c_PID_NAK);
    assign w_accept = r_ready && pkt_start && w_pid_ok;
    assign w_reject = r_ready && pkt_start && !w_pid_ok;

    // Every state other than IDLE/DONE puts a packet bit on the wire.
    assign w_field  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_adv    = w_field && !pause;

    assign w_pid_byte = {~r_pid, r_pid};

    // The bit on outb this cycle is the one consumed on an advancing edge,
    // so it is what feeds the running CRC.
    assign w_crc5_nxt  = (w_adv && ((r_state == S_ADDR) || (r_state == S_ENDP)))
                         ? f_crc5_step(r_crc5, r_outb) : r_crc5;
    assign w_crc16_nxt = (w_adv && (r_state == S_DATA))
                         ? f_crc16_step(r_crc16, r_outb) : r_crc16;

    always_comb begin
        w_last = 7'd7;
        case (r_state)
            S_ADDR:  w_last = 7'd6;
            S_ENDP:  w_last = 7'd3;
            S_CRC5:  w_last = 7'd4;
            S_DATA:  w_last = 7'd63;
            S_CRC16: w_last = 7'd15;
            default: w_last = 7'd7;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SYNC;
                    w_cnt_nxt   = 7'd0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 7'd0;
            end
            default: begin
                if (w_adv) begin
                    if (r_cnt == w_last) begin
                        w_cnt_nxt = 7'd0;
                        case (r_state)
                            S_SYNC:  w_state_nxt = S_PID;
                            S_PID: begin
                                if ((r_pid == c_PID_OUT) || (r_pid == c_PID_IN))
                                    w_state_nxt = S_ADDR;
                                else if (r_pid == c_PID_DATA0)
                                    w_state_nxt = S_DATA;
                                else
                                    w_state_nxt = S_DONE;
                            end
                            S_ADDR:  w_state_nxt = S_ENDP;
                            S_ENDP:  w_state_nxt = S_CRC5;
                            S_DATA:  w_state_nxt = S_CRC16;
                            default: w_state_nxt = S_DONE;
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + 7'd1;
                    end
                end
            end
        endcase
    end

    // Select the bit that will sit on outb after this edge. CRC fields are
    // sent complemented, MSB first, from the CRC value after this edge so
    // the final field bit is already folded in when the CRC field starts.
    assign w_idx5  = 3'd4 - w_cnt_nxt[2:0];
    assign w_idx16 = 4'd15 - w_cnt_nxt[3:0];

    always_comb begin
        w_bit_nxt = 1'b0;
        case (w_state_nxt)
            S_SYNC:  w_bit_nxt = SYNC_PAT[w_cnt_nxt[2:0]];
            S_PID:   w_bit_nxt = w_pid_byte[w_cnt_nxt[2:0]];
            S_ADDR:  w_bit_nxt = r_addr[w_cnt_nxt[2:0]];
            S_ENDP:  w_bit_nxt = r_endp[w_cnt_nxt[1:0]];
            S_CRC5:  w_bit_nxt = ~w_crc5_nxt[w_idx5];
            S_DATA:  w_bit_nxt = r_data[w_cnt_nxt[5:0]];
            S_CRC16: w_bit_nxt = ~w_crc16_nxt[w_idx16];
            default: w_bit_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state   <= S_IDLE;
            r_cnt     <= 7'd0;
            r_pid     <= 4'd0;
            r_addr    <= 7'd0;
            r_endp    <= 4'd0;
            r_data    <= 64'd0;
            r_crc5    <= 5'h1F;
            r_crc16   <= 16'hFFFF;
            r_ready   <= 1'b1;
            r_sending <= 1'b0;
            r_outb    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_outb    <= w_bit_nxt;
            r_crc5    <= w_accept ? 5'h1F : w_crc5_nxt;
            r_crc16   <= w_accept ? 16'hFFFF : w_crc16_nxt;
            if (w_accept) begin
                r_pid  <= pid;
                r_addr <= addr;
                r_endp <= endp;
                r_data <= data;
            end
            r_error   <= w_reject;
            r_done    <= (w_state_nxt == S_DONE);
            r_ready   <= (w_state_nxt == S_IDLE);
            r_sending <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        end
    end

    assign ready   = r_ready;
    assign sending = r_sending;
    assign outb    = r_outb;
    assign done    = r_done;
    assign error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bitstream_encoder_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitstream_encoder_tx
//  Description : Directed self-checking bench for bitstream_encoder_tx.
//                Captures consumed wire bits (first bit at index 0) and
//                compares against hand-computed streams and a CRC model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bitstream_encoder_tx;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        pkt_start = 1'b0;
    logic [3:0]  pid = 4'd0;
    logic [6:0]  addr = 7'd0;
    logic [3:0]  endp = 4'd0;
    logic [63:0] data = 64'd0;
    logic        pause = 1'b0;
    logic        ready;
    logic        sending;
    logic        outb;
    logic        done;
    logic        error;

    bitstream_encoder_tx #(.SYNC_PAT(8'b1000_0000)) dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .pkt_start (pkt_start),
        .pid       (pid),
        .addr      (addr),
        .endp      (endp),
        .data      (data),
        .pause     (pause),
        .ready     (ready),
        .sending   (sending),
        .outb      (outb),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [127:0] cap;
    int           cap_len;
    int           send_cyc;
    int           npause;
    int           busy_ready;

    function automatic logic [4:0] m_crc5(input logic [4:0] c, input logic b);
        logic [4:0] n;
        n = {c[3:0], 1'b0};
        if (c[4] ^ b) n = n ^ 5'b00101;
        return n;
    endfunction

    function automatic logic [15:0] m_crc16(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = {c[14:0], 1'b0};
        if (c[15] ^ b) n = n ^ 16'h8005;
        return n;
    endfunction

    function automatic logic [15:0] m_crc16_of(input logic [63:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) c = m_crc16(c, d[i]);
        return c;
    endfunction

    // Reference wire image of a packet, first bit at index 0.
    task automatic build_exp(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                             input logic [63:0] d, output logic [127:0] v, output int n);
        logic [7:0]  sy;
        logic [7:0]  pb;
        logic [4:0]  c5;
        logic [15:0] c16;
        sy = 8'b1000_0000;
        pb = {~p, p};
        v  = '0;
        n  = 0;
        for (int i = 0; i < 8; i++) begin v[n] = sy[i]; n++; end
        for (int i = 0; i < 8; i++) begin v[n] = pb[i]; n++; end
        if (p == 4'b0001 || p == 4'b1001) begin
            c5 = 5'h1F;
            for (int i = 0; i < 7; i++) begin v[n] = a[i]; c5 = m_crc5(c5, a[i]); n++; end
            for (int i = 0; i < 4; i++) begin v[n] = e[i]; c5 = m_crc5(c5, e[i]); n++; end
            for (int i = 4; i >= 0; i--) begin v[n] = ~c5[i]; n++; end
        end else if (p == 4'b0011) begin
            c16 = m_crc16_of(d);
            for (int i = 0; i < 64; i++) begin v[n] = d[i]; n++; end
            for (int i = 15; i >= 0; i--) begin v[n] = ~c16[i]; n++; end
        end
    endtask

    // Called and returns at a falling edge. pmod>0 pauses every pmod-th
    // sending cycle; poke keeps pkt_start high and scrambles inputs while busy.
    task automatic run_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d, input int pmod, input bit poke);
        bit fin;
        pid = p; addr = a; endp = e; data = d; pkt_start = 1'b1;
        cap = '0; cap_len = 0; send_cyc = 0; npause = 0; busy_ready = 0; fin = 1'b0;
        @(negedge clk);
        if (poke) begin
            pid = 4'b1010; addr = ~a; endp = ~e; data = ~d;
        end else begin
            pkt_start = 1'b0;
        end
        for (int k = 0; k < 300 && !fin; k++) begin
            pause = 1'b0;
            if (sending) begin
                if (ready) busy_ready++;
                if (pmod > 0 && (send_cyc % pmod) == pmod - 1) begin
                    pause = 1'b1;
                    npause++;
                end else begin
                    if (cap_len < 128) cap[cap_len] = outb;
                    cap_len++;
                end
                send_cyc++;
            end else if (done) begin
                check_val("done_outb", {127'd0, outb}, 128'd0);
                check_val("done_ready", {127'd0, ready}, 128'd0);
                fin = 1'b1;
                pkt_start = 1'b0;
            end
            @(negedge clk);
        end
        pause = 1'b0;
        pkt_start = 1'b0;
        check_val("done_seen", {127'd0, fin}, 128'd1);
        check_val("busy_ready", busy_ready, 0);
        check_val("ready_after_done", {127'd0, ready}, 128'd1);
        check_val("done_one_cycle", {127'd0, done}, 128'd0);
    endtask

    logic [127:0] exp_v;
    int           exp_n;
    logic [127:0] unpaused;
    logic [15:0]  rx_crc;
    logic [63:0]  d3;
    bit           havepkt;
    int           n40;
    int           bad;

    initial begin
        d3 = 64'h0040_0000_0100_0680;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready",   {127'd0, ready},   128'd1);
        check_val("rst_sending", {127'd0, sending}, 128'd0);
        check_val("rst_outb",    {127'd0, outb},    128'd0);
        check_val("rst_done",    {127'd0, done},    128'd0);
        check_val("rst_error",   {127'd0, error},   128'd0);
        rst_L = 1'b1;
        @(negedge clk);

        // 1: ACK with busy pkt_start and changing inputs
        run_pkt(4'b0010, 7'd0, 4'd0, 64'd0, 0, 1'b1);
        check_val("ack_len",  cap_len, 16);
        check_val("ack_bits", {112'd0, cap[15:0]}, 128'h0000_D280);
        check_val("ack_sendcyc", send_cyc, 16);

        // 2: OUT addr=0 endp=0, back-to-back after the ACK
        run_pkt(4'b0001, 7'd0, 4'd0, 64'd0, 0, 1'b0);
        check_val("out_len",   cap_len, 32);
        check_val("out_bits",  {96'd0, cap[31:0]}, 128'h1000_E180);
        check_val("out_pid",   {120'd0, cap[15:8]}, 128'hE1);
        check_val("out_crc5",  {123'd0, cap[31:27]}, 128'b00010);

        // 3: DATA0 with software decode of the captured stream
        run_pkt(4'b0011, 7'd0, 4'd0, d3, 0, 1'b0);
        build_exp(4'b0011, 7'd0, 4'd0, d3, exp_v, exp_n);
        check_val("data_len",  cap_len, 96);
        check_val("data_bits", {32'd0, cap[95:0]}, {32'd0, exp_v[95:0]});
        for (int i = 0; i < 16; i++) rx_crc[15 - i] = cap[80 + i];
        havepkt = (cap[7:0] == 8'h80) && (cap[11:8] == 4'b0011) &&
                  (cap[15:12] == ~cap[11:8]) && (cap[79:16] == d3) &&
                  (rx_crc == ~m_crc16_of(cap[79:16]));
        check_val("dec_havepkt", {127'd0, havepkt}, 128'd1);
        check_val("dec_pid",  {124'd0, cap[11:8]}, 128'b0011);
        check_val("dec_data", {64'd0, cap[79:16]}, {64'd0, d3});

        // 4: IN unpaused, then paused every 3rd cycle
        run_pkt(4'b1001, 7'h3A, 4'hA, 64'd0, 0, 1'b0);
        unpaused = cap;
        build_exp(4'b1001, 7'h3A, 4'hA, 64'd0, exp_v, exp_n);
        check_val("in_len",  cap_len, 32);
        check_val("in_bits", {96'd0, cap[31:0]}, {96'd0, exp_v[31:0]});
        run_pkt(4'b1001, 7'h3A, 4'hA, 64'd0, 3, 1'b0);
        check_val("inp_len",  cap_len, 32);
        check_val("inp_same", cap, unpaused);
        check_val("inp_sendcyc", send_cyc, 32 + npause);
        check_val("inp_paused", {127'd0, (npause > 0)}, 128'd1);

        // 5: unsupported pid
        pid = 4'b0110; pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        check_val("err_pulse",   {127'd0, error},   128'd1);
        check_val("err_sending", {127'd0, sending}, 128'd0);
        check_val("err_ready",   {127'd0, ready},   128'd1);
        @(negedge clk);
        check_val("err_clear",    {127'd0, error},   128'd0);
        check_val("err_sending2", {127'd0, sending}, 128'd0);

        // 6: reset at bit 40 of a DATA0, then a clean ACK
        pid = 4'b0011; data = d3; pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        n40 = 0;
        for (int k = 0; k < 200 && n40 < 40; k++) begin
            if (sending) n40++;
            @(negedge clk);
        end
        check_val("rst_reach40", n40, 40);
        rst_L = 1'b0;
        #1;
        check_val("mid_rst_sending", {127'd0, sending}, 128'd0);
        check_val("mid_rst_ready",   {127'd0, ready},   128'd1);
        check_val("mid_rst_outb",    {127'd0, outb},    128'd0);
        check_val("mid_rst_done",    {127'd0, done},    128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_L = 1'b1;
        bad = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (done || sending) bad++;
        end
        check_val("post_rst_quiet", bad, 0);
        run_pkt(4'b0010, 7'd0, 4'd0, 64'd0, 0, 1'b0);
        check_val("post_rst_ack", {112'd0, cap[15:0]}, 128'h0000_D280);
        check_val("post_rst_len", cap_len, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
